pipe_rf_alu_dm: RTL and testbench

PIPE_RF_ALU_DM -- requirements
Module: pipe_rf_alu_dm

---
 rtl/pipe_rf_alu_dm.sv | 183 ++++++++++++++++++
 tb/tb_pipe_rf_alu_dm.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rf_alu_dm.sv
// pipe_rf_alu_dm : three-stage datapath.
//   X : register-file read with forwarding, sign extension and ALU (combinational
//       on the issuing instruction's inputs)
//   M : EX/MEM register, word-addressed data-memory access
//   W : MEM/WB register, register-file write at the edge ending W
//
// Ports
//   clock, reset                    sole rising-edge clock; asynchronous active-high reset
//   valid_in / ready_out            issue handshake; an instruction is taken when both are high
//   ALUop, rs, rt, rd, SEin         operation class, register numbers, immediate (SEin[5:0] = function)
//   RegWrite, RegDst, ALUSrc,
//   MemtoReg, MemWrite, MemRead     per-instruction control fields
//   alu_result, Zero                combinational ALU output of the issuing instruction
//   wb_valid, wb_reg, wb_data       register write that occurs at the next edge
module pipe_rf_alu_dm #(
   parameter int WIDTH    = 32,
   parameter int NREG     = 32,
   parameter int DM_DEPTH = 256
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      valid_in,
   output logic                      ready_out,
   input  logic [1:0]                ALUop,
   input  logic [$clog2(NREG)-1:0]   rs,
   input  logic [$clog2(NREG)-1:0]   rt,
   input  logic [$clog2(NREG)-1:0]   rd,
   input  logic [15:0]               SEin,
   input  logic                      RegWrite,
   input  logic                      RegDst,
   input  logic                      ALUSrc,
   input  logic                      MemtoReg,
   input  logic                      MemWrite,
   input  logic                      MemRead,
   output logic [WIDTH-1:0]          alu_result,
   output logic                      Zero,
   output logic                      wb_valid,
   output logic [$clog2(NREG)-1:0]   wb_reg,
   output logic [WIDTH-1:0]          wb_data
);

   localparam int RA = $clog2(NREG);
   localparam int DA = $clog2(DM_DEPTH);

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_ZERO
   } alu_op_e;

   // M stage
   logic             m_valid_q, m_regwrite_q, m_memtoreg_q, m_memwrite_q, m_memread_q;
   logic [RA-1:0]    m_dst_q;
   logic [WIDTH-1:0] m_alu_q, m_store_q;
   // W stage
   logic             w_valid_q, w_regwrite_q;
   logic [RA-1:0]    w_dst_q;
   logic [WIDTH-1:0] w_data_q, w_data_d;

   logic [WIDTH-1:0] rf_q [NREG];
   logic [WIDTH-1:0] dm_q [DM_DEPTH];

   logic [WIDTH-1:0] rs_val, rt_val, imm_ext, op_b;
   logic [WIDTH-1:0] dm_rdata;
   logic [DA-1:0]    dm_addr;
   logic             m_fwd_ok, load_in_m, accept, m_valid_d;
   alu_op_e          alu_op;

   // ---------------- X stage ----------------
   assign imm_ext = WIDTH'($signed(SEin));

   // Only a non-load in M has its result ready; a load in M is covered by the stall.
   assign m_fwd_ok = m_valid_q & m_regwrite_q & ~m_memread_q & (m_dst_q != '0);

   // NOTE: every output of a combinational block gets a default (or a full
   // if/else chain) so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      if (rs == '0)                        rs_val = '0;
      else if (m_fwd_ok && m_dst_q == rs)  rs_val = m_alu_q;
      else if (wb_valid && w_dst_q == rs)  rs_val = w_data_q;   // also the write-through path
      else                                 rs_val = rf_q[rs];
   end

   always_comb begin
      if (rt == '0)                        rt_val = '0;
      else if (m_fwd_ok && m_dst_q == rt)  rt_val = m_alu_q;
      else if (wb_valid && w_dst_q == rt)  rt_val = w_data_q;
      else                                 rt_val = rf_q[rt];
   end

   assign op_b = ALUSrc ? imm_ext : rt_val;

   always_comb begin
      alu_op = ALU_ZERO;
      unique case (ALUop)
         2'b00: alu_op = ALU_ADD;
         2'b01: alu_op = ALU_SUB;
         2'b11: alu_op = ALU_AND;
         2'b10: begin
            case (SEin[5:0])
               6'h20:   alu_op = ALU_ADD;
               6'h22:   alu_op = ALU_SUB;
               6'h24:   alu_op = ALU_AND;
               6'h25:   alu_op = ALU_OR;
               6'h27:   alu_op = ALU_NOR;
               6'h2A:   alu_op = ALU_SLT;
               default: alu_op = ALU_ZERO;
            endcase
         end
      endcase
   end

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD: alu_result = rs_val + op_b;
         ALU_SUB: alu_result = rs_val - op_b;
         ALU_AND: alu_result = rs_val & op_b;
         ALU_OR:  alu_result = rs_val | op_b;
         ALU_NOR: alu_result = ~(rs_val | op_b);
         ALU_SLT: alu_result[0] = $signed(rs_val) < $signed(op_b);
         default: alu_result = '0;
      endcase
   end

   assign Zero = valid_in & (alu_result == '0);

   // Load-use hazard: the loaded value only exists once the load reaches W.
   // rt only matters for the ALU when ALUSrc selects it.
   assign load_in_m = m_valid_q & m_memread_q & m_regwrite_q & (m_dst_q != '0);
   assign ready_out = ~(load_in_m & ((m_dst_q == rs) | ((m_dst_q == rt) & ~ALUSrc)));
   assign accept    = valid_in & ready_out;
   assign m_valid_d = accept;   // a refused or absent instruction becomes a bubble

   // ---------------- M stage ----------------
   assign dm_addr  = m_alu_q[DA-1:0];   // word address, upper bits ignored
   assign dm_rdata = dm_q[dm_addr];     // read returns the pre-write contents
   assign w_data_d = m_memtoreg_q ? dm_rdata : m_alu_q;

   // NOTE: the data memory has no reset; its contents survive reset and the
   // array stays a plain RAM. The register file below is cleared by reset.
   always_ff @(posedge clock) begin
      if (m_valid_q && m_memwrite_q) dm_q[dm_addr] <= m_store_q;
   end

   // ---------------- W stage ----------------
   assign wb_valid = w_valid_q & w_regwrite_q & (w_dst_q != '0);
   assign wb_reg   = w_dst_q;
   assign wb_data  = w_data_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m_valid_q    <= 1'b0;
         m_regwrite_q <= 1'b0;
         m_memtoreg_q <= 1'b0;
         m_memwrite_q <= 1'b0;
         m_memread_q  <= 1'b0;
         m_dst_q      <= '0;
         m_alu_q      <= '0;
         m_store_q    <= '0;
         w_valid_q    <= 1'b0;
         w_regwrite_q <= 1'b0;
         w_dst_q      <= '0;
         w_data_q     <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         m_valid_q    <= m_valid_d;
         m_regwrite_q <= RegWrite;
         m_memtoreg_q <= MemtoReg;
         m_memwrite_q <= MemWrite;
         m_memread_q  <= MemRead;
         m_dst_q      <= RegDst ? rd : rt;
         m_alu_q      <= alu_result;
         m_store_q    <= rt_val;
         w_valid_q    <= m_valid_q;
         w_regwrite_q <= m_regwrite_q;
         w_dst_q      <= m_dst_q;
         w_data_q     <= w_data_d;
         if (wb_valid) rf_q[w_dst_q] <= w_data_q;
      end
   end

endmodule

// File: tb/tb_pipe_rf_alu_dm.sv
// Self-checking bench for pipe_rf_alu_dm. A 32-bit instance runs directed
// cases and a random instruction stream against an instruction-level model
// (architectural registers, memory array, two-deep write-back timeline).
// A 16-bit / 8-register / 16-word instance checks narrow sign extension and
// address wrap.
module tb_pipe_rf_alu_dm;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, valid_in, RegWrite, RegDst, ALUSrc, MemtoReg, MemWrite, MemRead;
   logic [1:0]  ALUop;
   logic [4:0]  rs, rt, rd;
   logic [15:0] SEin;
   logic        ready_out, Zero, wb_valid;
   logic [31:0] alu_result, wb_data;
   logic [4:0]  wb_reg;

   pipe_rf_alu_dm dut (
      .clock(clock), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
      .ALUop(ALUop), .rs(rs), .rt(rt), .rd(rd), .SEin(SEin),
      .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
      .MemWrite(MemWrite), .MemRead(MemRead), .alu_result(alu_result), .Zero(Zero),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
   );

   // narrow instance
   logic        s_valid, s_ready, s_rw, s_rdst, s_asrc, s_m2r, s_mw, s_mr, s_zero, s_wbv;
   logic [1:0]  s_aluop;
   logic [2:0]  s_rs, s_rt, s_rd, s_wbr;
   logic [15:0] s_se, s_alu, s_wbd;

   pipe_rf_alu_dm #(.WIDTH(16), .NREG(8), .DM_DEPTH(16)) dut16 (
      .clock(clock), .reset(reset), .valid_in(s_valid), .ready_out(s_ready),
      .ALUop(s_aluop), .rs(s_rs), .rt(s_rt), .rd(s_rd), .SEin(s_se),
      .RegWrite(s_rw), .RegDst(s_rdst), .ALUSrc(s_asrc), .MemtoReg(s_m2r),
      .MemWrite(s_mw), .MemRead(s_mr), .alu_result(s_alu), .Zero(s_zero),
      .wb_valid(s_wbv), .wb_reg(s_wbr), .wb_data(s_wbd)
   );

   typedef struct packed {
      logic [1:0]  aluop;
      logic [4:0]  rs, rt, rd;
      logic [15:0] se;
      logic        rw, rdst, asrc, m2r, mw, mr;
   } instr_t;

   typedef struct packed {
      logic        v;      // slot holds an accepted instruction
      logic        ld;     // MemRead & RegWrite
      logic [4:0]  dst;
      logic        wbv;    // a visible register write is expected
      logic [31:0] data;
   } stage_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] arch_rf [32];
   logic [31:0] mem_m   [256];
   stage_t      pm, pw;    // instructions accepted one and two edges ago

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'd0: return a + b;
         2'd1: return a - b;
         2'd3: return a & b;
         default: begin
            case (fn)
               6'h20:   return a + b;
               6'h22:   return a - b;
               6'h24:   return a & b;
               6'h25:   return a | b;
               6'h27:   return ~(a | b);
               6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: return 32'd0;
            endcase
         end
      endcase
   endfunction

   function automatic instr_t imm_op(input logic [1:0] op, input logic [4:0] s, input logic [4:0] t,
                                     input logic [15:0] se);
      instr_t i = '0;
      i.aluop = op; i.rs = s; i.rt = t; i.se = se; i.asrc = 1'b1; i.rw = 1'b1;
      return i;
   endfunction

   function automatic instr_t r_op(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                   input logic [5:0] fn);
      instr_t i = '0;
      i.aluop = 2'd2; i.rs = s; i.rt = t; i.rd = d; i.se = {10'd0, fn}; i.rdst = 1'b1; i.rw = 1'b1;
      return i;
   endfunction

   function automatic instr_t ld_op(input logic [4:0] s, input logic [4:0] t, input logic [15:0] se);
      instr_t i = imm_op(2'd0, s, t, se);
      i.mr = 1'b1; i.m2r = 1'b1;
      return i;
   endfunction

   function automatic instr_t st_op(input logic [4:0] s, input logic [4:0] t, input logic [15:0] se);
      instr_t i = imm_op(2'd0, s, t, se);
      i.rw = 1'b0; i.mw = 1'b1;
      return i;
   endfunction

   function automatic instr_t rand_instr(input stage_t m);
      instr_t i = '0;
      logic [5:0] fns [7];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21};
      i.rs = 5'($urandom_range(0, 7));
      i.rt = 5'($urandom_range(0, 7));
      i.rd = 5'($urandom_range(0, 7));
      i.se = 16'($urandom);
      case ($urandom_range(0, 5))
         0: begin i.aluop = 2'd2; i.se[5:0] = fns[$urandom_range(0, 6)]; i.rdst = 1'b1; i.rw = 1'b1; end
         1: begin
            i.aluop = 2'($urandom_range(0, 2));
            if (i.aluop == 2'd2) i.aluop = 2'd3;
            i.asrc = 1'b1; i.rw = 1'b1;
         end
         2: begin i.aluop = 2'($urandom_range(0, 3)); i.rdst = 1'b1; i.rw = 1'b1; end
         3: begin i = ld_op(5'd0, i.rt, 16'($urandom_range(0, 15))); end
         4: begin
            i = st_op(5'd0, i.rt, 16'($urandom_range(0, 15)));
            // store data skips a load still in M, so keep that pairing out of the stream
            if (m.v && m.ld && m.dst == i.rt) i.rt = 5'd0;
         end
         default: begin i.aluop = 2'($urandom_range(0, 3)); i.asrc = 1'($urandom); end
      endcase
      return i;
   endfunction

   task automatic model_reset();
      pm = '0;
      pw = '0;
      for (int k = 0; k < 32; k++) arch_rf[k] = 32'd0;
   endtask

   task automatic sample_wb(input string tag);
      chk({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, pw.v & pw.wbv});
      if (pw.v && pw.wbv) begin
         chk({tag, ".wb_reg"},  {27'd0, wb_reg}, {27'd0, pw.dst});
         chk({tag, ".wb_data"}, wb_data, pw.data);
      end
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         sample_wb("idle");
         chk("idle.zero", {31'd0, Zero}, 32'd0);
         @(posedge clock); #1;
         pw = pm;
         pm = '0;
      end
   endtask

   task automatic issue(input instr_t i, input string tag);
      logic [31:0] a, b, res, ld_data;
      logic        rdy;
      logic [4:0]  dst;
      stage_t      nm;
      ALUop = i.aluop; rs = i.rs; rt = i.rt; rd = i.rd; SEin = i.se;
      RegWrite = i.rw; RegDst = i.rdst; ALUSrc = i.asrc; MemtoReg = i.m2r;
      MemWrite = i.mw; MemRead = i.mr; valid_in = 1'b1;
      for (int t = 0; t < 2; t++) begin
         @(negedge clock);
         sample_wb(tag);
         rdy = !(pm.v && pm.ld && pm.dst != 5'd0 &&
                 (pm.dst == i.rs || (pm.dst == i.rt && !i.asrc)));
         chk({tag, ".ready"}, {31'd0, ready_out}, {31'd0, rdy});
         a   = arch_rf[i.rs];
         b   = i.asrc ? {{16{i.se[15]}}, i.se} : arch_rf[i.rt];
         res = ref_alu(i.aluop, i.se[5:0], a, b);
         if (rdy) begin
            chk({tag, ".alu"},  alu_result, res);
            chk({tag, ".zero"}, {31'd0, Zero}, {31'd0, res == 32'd0});
         end
         @(posedge clock); #1;
         nm = '0;
         if (rdy) begin
            dst     = i.rdst ? i.rd : i.rt;
            ld_data = mem_m[res[7:0]];
            if (i.mw) mem_m[res[7:0]] = arch_rf[i.rt];
            nm.v    = 1'b1;
            nm.ld   = i.mr & i.rw;
            nm.dst  = dst;
            nm.wbv  = i.rw && dst != 5'd0;
            nm.data = i.m2r ? ld_data : res;
            if (nm.wbv) arch_rf[dst] = nm.data;
         end
         pw = pm;
         pm = nm;
         if (rdy) break;
      end
      valid_in = 1'b0;
   endtask

   task automatic s_issue(input logic [2:0] s, input logic [2:0] t, input logic [15:0] se,
                          input logic rw, input logic m2r, input logic mw, input logic mr,
                          input logic [15:0] exp_alu, input logic exp_wbv, input logic [15:0] exp_wbd,
                          input string tag);
      s_aluop = 2'd0; s_rs = s; s_rt = t; s_rd = 3'd0; s_se = se; s_rw = rw; s_rdst = 1'b0;
      s_asrc = 1'b1; s_m2r = m2r; s_mw = mw; s_mr = mr; s_valid = 1'b1;
      #1;
      chk({tag, ".ready"}, {31'd0, s_ready}, 32'd1);
      chk({tag, ".alu"},   {16'd0, s_alu}, {16'd0, exp_alu});
      chk({tag, ".zero"},  {31'd0, s_zero}, {31'd0, exp_alu == 16'd0});
      @(posedge clock); #1;
      s_valid = 1'b0;
      @(posedge clock); #1;
      chk({tag, ".wb_valid"}, {31'd0, s_wbv}, {31'd0, exp_wbv});
      if (exp_wbv) begin
         chk({tag, ".wb_reg"},  {29'd0, s_wbr}, {29'd0, t});
         chk({tag, ".wb_data"}, {16'd0, s_wbd}, {16'd0, exp_wbd});
      end
      @(posedge clock); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; valid_in = 1'b0; ALUop = '0; rs = '0; rt = '0; rd = '0; SEin = '0;
      RegWrite = 1'b0; RegDst = 1'b0; ALUSrc = 1'b0; MemtoReg = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
      s_valid = 1'b0; s_aluop = '0; s_rs = '0; s_rt = '0; s_rd = '0; s_se = '0;
      s_rw = 1'b0; s_rdst = 1'b0; s_asrc = 1'b0; s_m2r = 1'b0; s_mw = 1'b0; s_mr = 1'b0;

      // reset state
      #1 reset = 1'b1;
      #2;
      chk("rst.ready",     {31'd0, ready_out}, 32'd1);
      chk("rst.wb_valid",  {31'd0, wb_valid}, 32'd0);
      chk("rst.wb_reg",    {27'd0, wb_reg}, 32'd0);
      chk("rst16.ready",   {31'd0, s_ready}, 32'd1);
      chk("rst16.wb_valid", {31'd0, s_wbv}, 32'd0);
      model_reset();
      @(posedge clock); #1;
      reset = 1'b0;

      // r1 = r0 + 5, write-back visible one cycle after M
      issue(imm_op(2'd0, 5'd0, 5'd1, 16'd5), "addi_r1");
      idle(2);

      // back-to-back dependency through M
      issue(imm_op(2'd0, 5'd0, 5'd1, 16'd5), "b2b_r1");
      issue(r_op(5'd1, 5'd1, 5'd2, 6'h20), "b2b_add");
      // M result wins over an older W result for the same register
      issue(imm_op(2'd0, 5'd0, 5'd1, 16'd6), "prio_r1a");
      issue(imm_op(2'd0, 5'd0, 5'd1, 16'd7), "prio_r1b");
      issue(r_op(5'd1, 5'd1, 5'd2, 6'h20), "prio_add");

      // store, load, dependent use (one stall cycle)
      issue(imm_op(2'd0, 5'd0, 5'd1, 16'd5), "lu_r1");
      issue(st_op(5'd0, 5'd1, 16'd3), "lu_store");
      issue(ld_op(5'd0, 5'd3, 16'd3), "lu_load");
      issue(r_op(5'd3, 5'd3, 5'd4, 6'h20), "lu_use");

      // read and write in one instruction: old data returned, new data stored
      issue(imm_op(2'd0, 5'd0, 5'd6, 16'h0077), "rw_r6");
      idle(1);
      issue(ld_op(5'd0, 5'd6, 16'd3), "rw_both");
      MemWrite = 1'b0;
      idle(1);
      begin
         instr_t both;
         both = ld_op(5'd0, 5'd7, 16'd3);
         issue(both, "rw_after");
      end
      begin
         instr_t both;
         both = ld_op(5'd0, 5'd9, 16'd4);
         both.rt = 5'd6;
         both.mw = 1'b1;
         issue(imm_op(2'd0, 5'd0, 5'd6, 16'h0055), "rw2_r6");
         idle(2);
         issue(both, "rw2_both");
         idle(2);
         issue(ld_op(5'd0, 5'd10, 16'd4), "rw2_check");
         idle(2);
      end

      // sign extension, slt, zero flag, remaining functions
      issue(imm_op(2'd0, 5'd0, 5'd8, 16'h8000), "sext");
      issue(imm_op(2'd0, 5'd0, 5'd9, 16'hFFFF), "neg1");
      issue(imm_op(2'd0, 5'd0, 5'd10, 16'd1), "one");
      issue(r_op(5'd9, 5'd10, 5'd11, 6'h2A), "slt_lt");
      issue(r_op(5'd10, 5'd9, 5'd12, 6'h2A), "slt_ge");
      issue(imm_op(2'd0, 5'd0, 5'd13, 16'd7), "seven");
      issue(imm_op(2'd1, 5'd13, 5'd14, 16'd7), "sub_zero");
      issue(r_op(5'd9, 5'd10, 5'd15, 6'h27), "nor");
      issue(r_op(5'd8, 5'd10, 5'd16, 6'h25), "or");
      issue(r_op(5'd9, 5'd10, 5'd17, 6'h21), "func_other");

      // register 0: write discarded, never forwarded
      issue(imm_op(2'd0, 5'd0, 5'd0, 16'd9), "r0_write");
      issue(r_op(5'd0, 5'd0, 5'd5, 6'h20), "r0_read_m");
      idle(2);
      issue(r_op(5'd0, 5'd0, 5'd5, 6'h20), "r0_read_rf");

      // known contents in words 0..15 for the random stream
      for (int k = 0; k < 16; k++) begin
         issue(imm_op(2'd0, 5'd0, 5'd1, 16'($urandom)), "init_val");
         issue(st_op(5'd0, 5'd1, 16'(k)), "init_st");
      end

      // random stream
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         issue(rand_instr(pm), "rnd");
      end
      idle(2);

      // reset with a load in M: no write-back, memory keeps earlier store
      issue(imm_op(2'd0, 5'd0, 5'd20, 16'h0ABC), "mr_val");
      issue(st_op(5'd0, 5'd20, 16'd5), "mr_store");
      idle(2);
      issue(ld_op(5'd0, 5'd21, 16'd5), "mr_load");
      reset = 1'b1;
      #1;
      chk("mr.wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("mr.ready",    {31'd0, ready_out}, 32'd1);
      model_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      idle(3);
      issue(ld_op(5'd0, 5'd22, 16'd5), "mr_reload");
      issue(r_op(5'd20, 5'd0, 5'd23, 6'h20), "mr_rf_clear");
      idle(3);

      // narrow instance: sign extension at 16 bits and address wrap
      s_issue(3'd0, 3'd1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h1234, "w16_set");
      s_issue(3'd0, 3'd1, 16'd17,   1'b0, 1'b0, 1'b1, 1'b0, 16'd17,   1'b0, 16'h0000, "w16_st17");
      s_issue(3'd0, 3'd2, 16'd1,    1'b1, 1'b1, 1'b0, 1'b1, 16'd1,    1'b1, 16'h1234, "w16_ld1");
      s_issue(3'd0, 3'd3, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1, 16'h8000, "w16_sext");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
